// File: rtl/taiga_config.sv
// Project-wide configuration constants shared by the load/store unit.
package taiga_config;

   localparam int SB_DEPTH = 4;

endpackage

// File: rtl/sb_forward_select.sv
// Picks the youngest set bit of an occupancy-qualified match vector, where age
// runs from head (oldest) towards tail (one past the youngest).
module sb_forward_select
   import taiga_config::*;
#(
   parameter int DEPTH = SB_DEPTH
) (
   input  logic [DEPTH-1:0]         match,
   input  logic [$clog2(DEPTH)-1:0] head,
   input  logic [$clog2(DEPTH)-1:0] tail,
   output logic [DEPTH-1:0]         youngest
);

   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0] span;
   logic [PW-1:0] idx;

   // Walk oldest to youngest so the last match seen wins. A zero span means
   // the ring is full (an empty ring produces no matches at all).
   always_comb begin
      youngest = '0;
      span     = tail - head;
      idx      = head;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + PW'(k);
         if (((span == '0) || (PW'(k) < span)) && match[idx]) begin
            youngest      = '0;
            youngest[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ls_store_buffer.sv
// Committed-store buffer: in-order FIFO to memory with youngest-entry
// coalescing and combinational store-to-load forwarding.
module ls_store_buffer
   import taiga_config::*;
#(
   parameter int DEPTH  = SB_DEPTH,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       st_valid,
   output logic                       st_ready,
   input  logic [ADDR_W-1:0]          st_addr,
   input  logic [DATA_W-1:0]          st_data,
   input  logic [DATA_W/8-1:0]        st_be,
   input  logic [ID_W-1:0]            st_id,
   input  logic                       ld_check,
   input  logic [ADDR_W-1:0]          ld_addr,
   input  logic [DATA_W/8-1:0]        ld_be,
   output logic                       fwd_hit,
   output logic [DATA_W-1:0]          fwd_data,
   output logic                       fwd_stall,
   output logic                       mem_valid,
   input  logic                       mem_ready,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [DATA_W-1:0]          mem_data,
   output logic [DATA_W/8-1:0]        mem_be,
   output logic [ID_W-1:0]            mem_id,
   output logic [$clog2(DEPTH):0]     sb_count,
   output logic                       sb_empty
);

   localparam int BE_W  = DATA_W / 8;
   localparam int OFF_W = $clog2(BE_W);
   localparam int WA_W  = ADDR_W - OFF_W;
   localparam int PW    = $clog2(DEPTH);
   localparam int CW    = PW + 1;

   typedef struct packed {
      logic [WA_W-1:0]   waddr;
      logic [DATA_W-1:0] data;
      logic [BE_W-1:0]   be;
      logic [ID_W-1:0]   id;
   } entry_t;

   entry_t        ent [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   logic [WA_W-1:0] st_waddr;
   logic [WA_W-1:0] ld_waddr;
   logic            unused_addr_bits;

   assign st_waddr         = st_addr[ADDR_W-1:OFF_W];
   assign ld_waddr         = ld_addr[ADDR_W-1:OFF_W];
   assign unused_addr_bits = ^{st_addr[OFF_W-1:0], ld_addr[OFF_W-1:0]};

   // Handshakes on both sides are plain valid/ready: a transfer happens on a
   // rising edge where valid and ready are both high; valid never waits on ready.
   logic          push;
   logic          pop;
   logic          coalesce;
   logic          alloc;
   logic [PW-1:0] yidx;

   assign st_ready  = (count != CW'(DEPTH));
   assign mem_valid = (count != '0);
   assign push      = st_valid & st_ready;
   assign pop       = mem_valid & mem_ready;
   assign yidx      = (tail == '0) ? PW'(DEPTH - 1) : tail - 1'b1;

   // Requiring two entries keeps the head (possibly mid-transfer) untouched.
   assign coalesce  = push && (count >= CW'(2)) && (ent[yidx].waddr == st_waddr);
   assign alloc     = push & ~coalesce;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (alloc) tail <= ptr_inc(tail);
         if (pop)   head <= ptr_inc(head);
         case ({alloc, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   entry_t new_ent;
   entry_t merged;

   always_comb begin
      new_ent.waddr = st_waddr;
      new_ent.data  = st_data;
      new_ent.be    = st_be;
      new_ent.id    = st_id;
      merged        = ent[yidx];
      for (int b = 0; b < BE_W; b++) begin
         if (st_be[b]) merged.data[b*8 +: 8] = st_data[b*8 +: 8];
      end
      merged.be = ent[yidx].be | st_be;
      merged.id = st_id;
   end

   // Entry payload is deliberately not reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (alloc) begin
         ent[tail] <= new_ent;
      end else if (coalesce) begin
         ent[yidx] <= merged;
      end
   end

   assign mem_addr = {ent[head].waddr, {OFF_W{1'b0}}};
   assign mem_data = ent[head].data;
   assign mem_be   = ent[head].be;
   assign mem_id   = ent[head].id;
   assign sb_count = count;
   assign sb_empty = (count == '0);

   logic [DEPTH-1:0] occupied;
   logic [DEPTH-1:0] match;
   logic [DEPTH-1:0] youngest;
   logic [PW-1:0]    off;

   always_comb begin
      occupied = '0;
      match    = '0;
      off      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off         = PW'(i) - head;
         occupied[i] = ({1'b0, off} < count);
         match[i]    = ld_check && occupied[i] && (ent[i].waddr == ld_waddr);
      end
   end

   sb_forward_select #(
      .DEPTH (DEPTH)
   ) u_select (
      .match    (match),
      .head     (head),
      .tail     (tail),
      .youngest (youngest)
   );

   logic [DATA_W-1:0] sel_data;
   logic [BE_W-1:0]   sel_be;
   logic              any_match;

   always_comb begin
      sel_data = '0;
      sel_be   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (youngest[i]) begin
            sel_data = sel_data | ent[i].data;
            sel_be   = sel_be | ent[i].be;
         end
      end
   end

   assign any_match = |match;
   assign fwd_hit   = any_match && ((sel_be & ld_be) == ld_be);
   assign fwd_stall = any_match && !fwd_hit;
   assign fwd_data  = fwd_hit ? sel_data : '0;

endmodule

// File: tb/tb_ls_store_buffer.sv
// Directed bench for ls_store_buffer: drain ordering, coalescing, forwarding,
// full-buffer back-pressure with wrap, and asynchronous reset.
module tb_ls_store_buffer;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;
   localparam int ID_W   = 3;
   localparam int CW     = 3;
   localparam int EW     = ADDR_W + DATA_W + BE_W + ID_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              st_valid;
   logic              st_ready;
   logic [ADDR_W-1:0] st_addr;
   logic [DATA_W-1:0] st_data;
   logic [BE_W-1:0]   st_be;
   logic [ID_W-1:0]   st_id;
   logic              ld_check;
   logic [ADDR_W-1:0] ld_addr;
   logic [BE_W-1:0]   ld_be;
   logic              fwd_hit;
   logic [DATA_W-1:0] fwd_data;
   logic              fwd_stall;
   logic              mem_valid;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic [BE_W-1:0]   mem_be;
   logic [ID_W-1:0]   mem_id;
   logic [CW-1:0]     sb_count;
   logic              sb_empty;

   int n_vec  = 0;
   int n_miss = 0;
   logic [EW-1:0] exp_q[$];

   ls_store_buffer #(
      .DEPTH (DEPTH), .ADDR_W (ADDR_W), .DATA_W (DATA_W), .ID_W (ID_W)
   ) dut (
      .clk (clk), .rst (rst),
      .st_valid (st_valid), .st_ready (st_ready), .st_addr (st_addr),
      .st_data (st_data), .st_be (st_be), .st_id (st_id),
      .ld_check (ld_check), .ld_addr (ld_addr), .ld_be (ld_be),
      .fwd_hit (fwd_hit), .fwd_data (fwd_data), .fwd_stall (fwd_stall),
      .mem_valid (mem_valid), .mem_ready (mem_ready), .mem_addr (mem_addr),
      .mem_data (mem_data), .mem_be (mem_be), .mem_id (mem_id),
      .sb_count (sb_count), .sb_empty (sb_empty)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish within time limit");
      $fatal(1);
   end

   task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Driver tasks (called just after a falling edge)
   task automatic push(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [2:0] id);
      st_valid = 1'b1;
      st_addr  = a;
      st_data  = d;
      st_be    = be;
      st_id    = id;
      @(negedge clk);
      st_valid = 1'b0;
   endtask

   task automatic expect_entry(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] be, input logic [2:0] id);
      exp_q.push_back({a, d, be, id});
   endtask

   task automatic drain(input int n);
      logic [EW-1:0] e;
      mem_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         e = exp_q.pop_front();
         check_vec("drain_mem_valid", 64'(mem_valid), 64'd1);
         check_vec("drain_mem_addr", 64'(mem_addr), 64'(e[70:39]));
         check_vec("drain_mem_data", 64'(mem_data), 64'(e[38:7]));
         check_vec("drain_mem_be", 64'(mem_be), 64'(e[6:3]));
         check_vec("drain_mem_id", 64'(mem_id), 64'(e[2:0]));
         @(negedge clk);
      end
      mem_ready = 1'b0;
   endtask

   task automatic load_chk(input string tag, input logic [31:0] a, input logic [3:0] be,
                           input logic h, input logic s, input logic [31:0] d);
      ld_check = 1'b1;
      ld_addr  = a;
      ld_be    = be;
      #1;
      check_vec({tag, "_hit"}, 64'(fwd_hit), 64'(h));
      check_vec({tag, "_stall"}, 64'(fwd_stall), 64'(s));
      check_vec({tag, "_data"}, 64'(fwd_data), 64'(d));
      ld_check = 1'b0;
   endtask

   initial begin
      rst       = 1'b0;
      st_valid  = 1'b0;
      st_addr   = '0;
      st_data   = '0;
      st_be     = '0;
      st_id     = '0;
      ld_check  = 1'b0;
      ld_addr   = '0;
      ld_be     = '0;
      mem_ready = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      check_vec("rst_count", 64'(sb_count), 64'd0);
      check_vec("rst_empty", 64'(sb_empty), 64'd1);
      check_vec("rst_mem_valid", 64'(mem_valid), 64'd0);
      check_vec("rst_st_ready", 64'(st_ready), 64'd1);
      load_chk("rst_fwd", 32'h0000_0000, 4'hF, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      // Four stores with memory stalled, then in-order drain
      push(32'h100, 32'hA0A0_0100, 4'hF, 3'd1);
      check_vec("lat_mem_valid", 64'(mem_valid), 64'd1);
      check_vec("lat_count", 64'(sb_count), 64'd1);
      push(32'h104, 32'hA0A0_0104, 4'hF, 3'd2);
      push(32'h108, 32'hA0A0_0108, 4'hF, 3'd3);
      push(32'h10C, 32'hA0A0_010C, 4'hF, 3'd4);
      check_vec("full_count", 64'(sb_count), 64'd4);
      check_vec("full_st_ready", 64'(st_ready), 64'd0);
      @(negedge clk);
      check_vec("stall_hold_addr", 64'(mem_addr), 64'h100);
      expect_entry(32'h100, 32'hA0A0_0100, 4'hF, 3'd1);
      expect_entry(32'h104, 32'hA0A0_0104, 4'hF, 3'd2);
      expect_entry(32'h108, 32'hA0A0_0108, 4'hF, 3'd3);
      expect_entry(32'h10C, 32'hA0A0_010C, 4'hF, 3'd4);
      drain(4);
      check_vec("drained_empty", 64'(sb_empty), 64'd1);

      // Coalesce into the youngest entry
      push(32'h200, 32'h0000_AABB, 4'b0011, 3'd1);
      push(32'h204, 32'h0000_1122, 4'b0011, 3'd2);
      push(32'h204, 32'hCCDD_0000, 4'b1100, 3'd3);
      check_vec("coal_count", 64'(sb_count), 64'd2);
      load_chk("coal_fwd", 32'h204, 4'hF, 1'b1, 1'b0, 32'hCCDD_1122);
      expect_entry(32'h200, 32'h0000_AABB, 4'b0011, 3'd1);
      expect_entry(32'h204, 32'hCCDD_1122, 4'b1111, 3'd3);
      drain(2);

      // A single entry is the head and must not absorb a store
      push(32'h500, 32'h0000_0011, 4'b0001, 3'd1);
      push(32'h500, 32'h0000_2200, 4'b0010, 3'd2);
      check_vec("head_nocoal_count", 64'(sb_count), 64'd2);
      push(32'h502, 32'h0033_0000, 4'b0100, 3'd3);
      check_vec("coal2_count", 64'(sb_count), 64'd2);
      load_chk("coal2_fwd", 32'h501, 4'b0010, 1'b1, 1'b0, 32'h0033_2200);
      expect_entry(32'h500, 32'h0000_0011, 4'b0001, 3'd1);
      expect_entry(32'h500, 32'h0033_2200, 4'b0110, 3'd3);
      drain(2);

      // Full forward hit, miss, and same-cycle store invisibility
      push(32'h300, 32'h1122_3344, 4'hF, 3'd5);
      load_chk("fwd_hit", 32'h302, 4'b1100, 1'b1, 1'b0, 32'h1122_3344);
      load_chk("fwd_miss", 32'h304, 4'hF, 1'b0, 1'b0, 32'h0);
      st_valid = 1'b1;
      st_addr  = 32'h600;
      st_data  = 32'h0000_0066;
      st_be    = 4'hF;
      st_id    = 3'd6;
      load_chk("same_cyc", 32'h600, 4'hF, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      st_valid = 1'b0;
      load_chk("next_cyc", 32'h600, 4'hF, 1'b1, 1'b0, 32'h0000_0066);
      expect_entry(32'h300, 32'h1122_3344, 4'hF, 3'd5);
      expect_entry(32'h600, 32'h0000_0066, 4'hF, 3'd6);
      drain(2);

      // Partial overlap stalls until the entry leaves
      push(32'h400, 32'h0000_00EE, 4'b0001, 3'd2);
      load_chk("partial", 32'h400, 4'hF, 1'b0, 1'b1, 32'h0);
      expect_entry(32'h400, 32'h0000_00EE, 4'b0001, 3'd2);
      drain(1);
      load_chk("after_pop", 32'h400, 4'hF, 1'b0, 1'b0, 32'h0);

      // Youngest of several matches wins
      push(32'h700, 32'h0000_0001, 4'hF, 3'd1);
      push(32'h704, 32'h0000_0044, 4'hF, 3'd2);
      push(32'h700, 32'h0000_0002, 4'hF, 3'd3);
      check_vec("young_count", 64'(sb_count), 64'd3);
      load_chk("young_fwd", 32'h700, 4'hF, 1'b1, 1'b0, 32'h0000_0002);
      load_chk("mid_fwd", 32'h704, 4'b0001, 1'b1, 1'b0, 32'h0000_0044);
      expect_entry(32'h700, 32'h0000_0001, 4'hF, 3'd1);
      expect_entry(32'h704, 32'h0000_0044, 4'hF, 3'd2);
      expect_entry(32'h700, 32'h0000_0002, 4'hF, 3'd3);
      drain(3);

      // Full buffer: store offered during a pop is refused, then accepted
      push(32'h800, 32'hB000_0800, 4'hF, 3'd1);
      push(32'h804, 32'hB000_0804, 4'hF, 3'd2);
      push(32'h808, 32'hB000_0808, 4'hF, 3'd3);
      push(32'h80C, 32'hB000_080C, 4'hF, 3'd4);
      st_valid  = 1'b1;
      st_addr   = 32'h810;
      st_data   = 32'hB000_0810;
      st_be     = 4'hF;
      st_id     = 3'd5;
      mem_ready = 1'b1;
      #1;
      check_vec("wrap_st_ready", 64'(st_ready), 64'd0);
      check_vec("wrap_pop_addr", 64'(mem_addr), 64'h800);
      @(negedge clk);
      mem_ready = 1'b0;
      check_vec("wrap_count3", 64'(sb_count), 64'd3);
      check_vec("wrap_ready_again", 64'(st_ready), 64'd1);
      @(negedge clk);
      st_valid = 1'b0;
      check_vec("wrap_count4", 64'(sb_count), 64'd4);
      expect_entry(32'h804, 32'hB000_0804, 4'hF, 3'd2);
      expect_entry(32'h808, 32'hB000_0808, 4'hF, 3'd3);
      expect_entry(32'h80C, 32'hB000_080C, 4'hF, 3'd4);
      expect_entry(32'h810, 32'hB000_0810, 4'hF, 3'd5);
      drain(4);

      // Asynchronous reset in the middle of a pending transfer
      push(32'h900, 32'hC000_0900, 4'hF, 3'd1);
      push(32'h904, 32'hC000_0904, 4'hF, 3'd2);
      push(32'h908, 32'hC000_0908, 4'hF, 3'd3);
      check_vec("pre_rst_count", 64'(sb_count), 64'd3);
      mem_ready = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      check_vec("async_rst_count", 64'(sb_count), 64'd0);
      check_vec("async_rst_mem_valid", 64'(mem_valid), 64'd0);
      check_vec("async_rst_st_ready", 64'(st_ready), 64'd1);
      check_vec("async_rst_empty", 64'(sb_empty), 64'd1);
      @(negedge clk);
      rst       = 1'b1;
      mem_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_vec("post_rst_idle", 64'(mem_valid), 64'd0);
      push(32'hA00, 32'hD000_0A00, 4'hF, 3'd1);
      check_vec("post_rst_store", 64'(mem_valid), 64'd1);
      expect_entry(32'hA00, 32'hD000_0A00, 4'hF, 3'd1);
      drain(1);
      check_vec("final_empty", 64'(sb_empty), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
